// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the handshaked data memory.
//   state_e      - FSM state encoding (IDLE / BUSY / DONE)
//   DefDepth     - default depth in words
//   DefLatency   - default request-to-response latency in cycles
//   DefVaddrW    - default video-port byte-address width
//   WordW        - data word width
//   merge_bytes  - byte-lane merge of a write into an existing word
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  localparam int unsigned DefDepth   = 32;
  localparam int unsigned DefLatency = 1;
  localparam int unsigned DefVaddrW  = 9;
  localparam int unsigned WordW      = 32;

  function automatic logic [WordW-1:0] merge_bytes(input logic [WordW-1:0]   old_word,
                                                   input logic [WordW-1:0]   wr_word,
                                                   input logic [WordW/8-1:0] be);
    logic [WordW-1:0] res;
    res = old_word;
    for (int k = 0; k < WordW / 8; k++) begin
      if (be[k]) res[8*k +: 8] = wr_word[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage for dmem_hs.
//   clk, reset_n     - clock; async active-low reset (video register only, never the array)
//   we, byte_en      - write strobe and byte-lane enables
//   waddr, wdata     - write word index and data
//   raddr, rdata     - combinational read port used by the FSM
//   vidx, vdata      - registered read port used by the video side
// Contents start at zero and survive reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               we,
  input  logic [WordW/8-1:0] byte_en,
  input  logic [AddrW-1:0]   waddr,
  input  logic [WordW-1:0]   wdata,
  input  logic [AddrW-1:0]   raddr,
  output logic [WordW-1:0]   rdata,
  input  logic [AddrW-1:0]   vidx,
  output logic [WordW-1:0]   vdata
);

  logic [WordW-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < WordW / 8; k++) begin
        if (byte_en[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

  // Sampled with the old contents on a same-edge write, so collisions return old data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vdata <= '0;
    end else begin
      vdata <= mem[vidx];
    end
  end

endmodule

// File: rtl/dmem_hs.sv
// dmem_hs: request/response data memory with a fixed-latency handshake and a
// registered video read port.
//   clk, reset_n   - clock; async active-low reset
//   req, we        - access request; 1 = write, 0 = read
//   byte_en        - write byte lanes
//   addr, wdata    - byte address (word index addr[31:2]) and write data
//   ready          - high in IDLE only
//   rvalid         - one-cycle response strobe (DONE state)
//   rdata, err     - response word and error flag, held between responses
//   vaddr, vdata   - video byte address and registered read data
// Optional build macro DMEM_BOUNDS_CHECK_EN: out-of-range word indices return
// err=1 / rdata=0 and never write; otherwise indices wrap and err is 0.
module dmem_hs
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = DefDepth,
  parameter int unsigned LATENCY = DefLatency,
  parameter int unsigned VADDR_W = DefVaddrW
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req,
  input  logic               we,
  input  logic [WordW/8-1:0] byte_en,
  input  logic [31:0]        addr,
  input  logic [WordW-1:0]   wdata,
  output logic               ready,
  output logic               rvalid,
  output logic [WordW-1:0]   rdata,
  output logic               err,
  input  logic [VADDR_W-1:0] vaddr,
  output logic [WordW-1:0]   vdata
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               we_q;
  logic [WordW/8-1:0] be_q;
  logic [29:0]        word_q;
  logic [WordW-1:0]   wdata_q;
  logic [WordW-1:0]   rdata_q;
  logic               err_q;

  logic               idle, accept, enter_done, oob, mem_we;
  logic               sel_we;
  logic [WordW/8-1:0] sel_be;
  logic [29:0]        sel_word;
  logic [WordW-1:0]   sel_wdata, mem_rdata, result;
  logic [29:0]        vword;

  assign idle   = (state_q == StIdle);
  assign accept = idle && req;

  // With LATENCY=1 the commit happens on the acceptance edge, before capture,
  // so the live inputs are used while IDLE.
  assign sel_we    = idle ? we : we_q;
  assign sel_be    = idle ? byte_en : be_q;
  assign sel_word  = idle ? addr[31:2] : word_q;
  assign sel_wdata = idle ? wdata : wdata_q;

`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob = (sel_word >> AddrW) != '0;
`else
  assign oob = 1'b0;
`endif

  assign vword = 30'(vaddr[VADDR_W-1:2]);

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], sel_word, vword, vaddr[1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_d    = StDone;
            enter_done = 1'b1;
          end else begin
            state_d = StBusy;
            cnt_d   = CntW'(LATENCY - 2);
          end
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d    = StDone;
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign mem_we = enter_done && sel_we && !oob;
  assign result = oob    ? '0 :
                  sel_we ? merge_bytes(mem_rdata, sel_wdata, sel_be) : mem_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we;
        be_q    <= byte_en;
        word_q  <= addr[31:2];
        wdata_q <= wdata;
      end
      if (enter_done) begin
        rdata_q <= result;
        err_q   <= oob;
      end
    end
  end

  assign ready  = idle;
  assign rvalid = (state_q == StDone);
  assign rdata  = rdata_q;
  assign err    = err_q;

  dmem_array #(
    .DEPTH(DEPTH),
    .AddrW(AddrW)
  ) u_array (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (mem_we),
    .byte_en(sel_be),
    .waddr  (sel_word[AddrW-1:0]),
    .wdata  (sel_wdata),
    .raddr  (sel_word[AddrW-1:0]),
    .rdata  (mem_rdata),
    .vidx   (vword[AddrW-1:0]),
    .vdata  (vdata)
  );

endmodule

// File: tb/tb_dmem_hs.sv
// tb_dmem_hs: two dmem_hs instances (LATENCY=1 and LATENCY=3) share one
// stimulus stream; each has its own expected-response queue drained by a monitor.
module tb_dmem_hs;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic        we;
  logic [3:0]  byte_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [8:0]  vaddr;

  logic        ready1, rvalid1, err1, ready3, rvalid3, err3;
  logic [31:0] rdata1, vdata1, rdata3, vdata3;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp1_q[$];
  logic [32:0] exp3_q[$];

  always #5 clk = ~clk;

  dmem_hs #(.DEPTH(32), .LATENCY(1), .VADDR_W(9)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .byte_en(byte_en), .addr(addr),
    .wdata(wdata), .ready(ready1), .rvalid(rvalid1), .rdata(rdata1), .err(err1),
    .vaddr(vaddr), .vdata(vdata1)
  );

  dmem_hs #(.DEPTH(32), .LATENCY(3), .VADDR_W(9)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .byte_en(byte_en), .addr(addr),
    .wdata(wdata), .ready(ready3), .rvalid(rvalid3), .rdata(rdata3), .err(err3),
    .vaddr(vaddr), .vdata(vdata3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon1
    logic [32:0] e;
    if (reset_n === 1'b1 && rvalid1 === 1'b1) begin
      if (exp1_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp1_unexpected: got rdata %h, required no response", rdata1);
      end else begin
        e = exp1_q.pop_front();
        chk("rdata1", rdata1, e[31:0]);
        chk("err1", {31'b0, err1}, {31'b0, e[32]});
      end
    end
  end

  always @(negedge clk) begin : mon3
    logic [32:0] e;
    if (reset_n === 1'b1 && rvalid3 === 1'b1) begin
      if (exp3_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp3_unexpected: got rdata %h, required no response", rdata3);
      end else begin
        e = exp3_q.pop_front();
        chk("rdata3", rdata3, e[31:0]);
        chk("err3", {31'b0, err3}, {31'b0, e[32]});
      end
    end
  end

  // Entered #1 after a posedge with both DUTs idle; returns likewise.
  task automatic access(input logic w, input logic [3:0] be, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] e1, input logic [31:0] e3,
                        input logic er, input logic vchk, input logic [31:0] vold,
                        input logic [31:0] vnew);
    chk("ready1_pre", {31'b0, ready1}, 32'd1);
    chk("ready3_pre", {31'b0, ready3}, 32'd1);
    exp1_q.push_back({er, e1});
    exp3_q.push_back({er, e3});
    req = 1'b1; we = w; byte_en = be; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("rvalid1_t", {31'b0, rvalid1}, {31'b0, (j == 0)});
      chk("ready1_t",  {31'b0, ready1},  {31'b0, (j >= 1)});
      chk("rvalid3_t", {31'b0, rvalid3}, {31'b0, (j == 2)});
      chk("ready3_t",  {31'b0, ready3},  {31'b0, (j == 3)});
      if (vchk) begin
        chk("vdata1", vdata1, (j >= 1) ? vnew : vold);
        chk("vdata3", vdata3, (j >= 3) ? vnew : vold);
      end
      if (j == 3) begin
        chk("rdata1_hold", rdata1, e1);
        chk("rdata3_hold", rdata3, e3);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; req = 1'b0; we = 1'b0; byte_en = 4'h0; addr = '0; wdata = '0;
    vaddr = 9'h010;
    #2;
    chk("rst_rvalid1", {31'b0, rvalid1}, 32'd0);
    chk("rst_rvalid3", {31'b0, rvalid3}, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_rdata3", rdata3, 32'd0);
    chk("rst_err3", {31'b0, err3}, 32'd0);
    chk("rst_vdata1", vdata1, 32'd0);
    #10 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready1", {31'b0, ready1}, 32'd1);
    chk("rst_ready3", {31'b0, ready3}, 32'd1);

    access(1, 4'hF, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1, 32'h0, 32'hDEADBEEF);
    access(0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF);
    access(1, 4'h1, 32'h10, 32'h000000AA, 32'hDEADBEAA, 32'hDEADBEAA, 0, 1,
           32'hDEADBEEF, 32'hDEADBEAA);
    access(1, 4'h0, 32'h10, 32'h12345678, 32'hDEADBEAA, 32'hDEADBEAA, 0, 1,
           32'hDEADBEAA, 32'hDEADBEAA);
    access(0, 4'h0, 32'h12, 32'h0, 32'hDEADBEAA, 32'hDEADBEAA, 0, 0, 32'h0, 32'h0);
    access(1, 4'hA, 32'h17, 32'h11223344, 32'h11003300, 32'h11003300, 0, 0, 32'h0, 32'h0);
    access(0, 4'h0, 32'h14, 32'h0, 32'h11003300, 32'h11003300, 0, 0, 32'h0, 32'h0);
    access(1, 4'hF, 32'h00, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 32'h0, 32'h0);
`ifdef DMEM_BOUNDS_CHECK_EN
    access(0, 4'h0, 32'h80, 32'h0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0);
    access(1, 4'hF, 32'h84, 32'h0BADCAFE, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0);
    access(0, 4'h0, 32'h04, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
`else
    access(0, 4'h0, 32'h80, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 32'h0, 32'h0);
    access(1, 4'hF, 32'h84, 32'h0BADCAFE, 32'h0BADCAFE, 32'h0BADCAFE, 0, 0, 32'h0, 32'h0);
    access(0, 4'h0, 32'h04, 32'h0, 32'h0BADCAFE, 32'h0BADCAFE, 0, 0, 32'h0, 32'h0);
`endif

    // Reset while the LATENCY=3 write is still BUSY; the LATENCY=1 one has committed.
    req = 1'b1; we = 1'b1; byte_en = 4'hF; addr = 32'h20; wdata = 32'h55AA55AA;
    @(posedge clk);
    #1 req = 1'b0;
    chk("busy_rdata1", rdata1, 32'h55AA55AA);
    chk("busy_rvalid3", {31'b0, rvalid3}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rvalid1", {31'b0, rvalid1}, 32'd0);
    chk("mid_rdata1", rdata1, 32'd0);
    chk("mid_rvalid3", {31'b0, rvalid3}, 32'd0);
    chk("mid_rdata3", rdata3, 32'd0);
    chk("mid_vdata3", vdata3, 32'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_ready3", {31'b0, ready3}, 32'd1);
    access(0, 4'h0, 32'h20, 32'h0, 32'h55AA55AA, 32'h0, 0, 0, 32'h0, 32'h0);
    access(0, 4'h0, 32'h10, 32'h0, 32'hDEADBEAA, 32'hDEADBEAA, 0, 1, 32'hDEADBEAA, 32'hDEADBEAA);

    repeat (2) @(posedge clk);
    chk("q1_empty", exp1_q.size(), 32'd0);
    chk("q3_empty", exp3_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
